uart_tx_fifo: RTL

//   Byte FIFO + drain FSM sitting directly upstream of the uart TX side. Buffers bytes

---
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers host writes and issues one byte
// per tx_data_valid pulse, only while the UART reports idle.
module uart_tx_fifo #(
   parameter int DEPTH        = 16,
   parameter int BUSY_TIMEOUT = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   wr_en_i,
   input  logic [7:0]             wr_data_i,
   input  logic                   flush_i,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o,
   output logic                   overflow_o,
   output logic                   timeout_err_o,
   output logic                   tx_data_valid_o,
   output logic [7:0]             tx_data_o,
   input  logic                   tx_busy_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

   state_e        state_q, state_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    tx_data_q, tx_data_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          overflow_q, overflow_d;
   logic          timeout_q, timeout_d;
   logic          full, empty, wr_fire, pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign wr_fire = wr_en_i && !full && !flush_i;
   assign pop     = (state_q == ISSUE) && !empty && !flush_i;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tx_data_d  = tx_data_q;
      overflow_d = overflow_q;
      timeout_d  = timeout_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      unique case (state_q)
         IDLE: begin
            if (!empty && !tx_busy_i && !flush_i) begin
               state_d   = ISSUE;
               tx_data_d = mem_q[rd_ptr_q[AW-1:0]];
            end
         end
         ISSUE: begin
            state_d = WAIT_BUSY;
            cnt_d   = '0;
         end
         WAIT_BUSY: begin
            if (tx_busy_i) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (wr_fire)           wr_ptr_d   = wr_ptr_q + 1'b1;
      if (pop)               rd_ptr_d   = rd_ptr_q + 1'b1;
      if (wr_en_i && full)   overflow_d = 1'b1;

      // Flush wins over write, pop and error capture; the FSM itself is left alone.
      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         overflow_d = 1'b0;
         timeout_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tx_data_q  <= 8'h00;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_data_q  <= tx_data_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
   end

   assign full_o          = full;
   assign empty_o         = empty;
   assign level_o         = wr_ptr_q - rd_ptr_q;
   assign overflow_o      = overflow_q;
   assign timeout_err_o   = timeout_q;
   assign tx_data_valid_o = (state_q == ISSUE);
   assign tx_data_o       = tx_data_q;

endmodule
